axi_lite_rd_arbiter: RTL and testbench

- Shares one downstream AXI4-Lite read master between two upstream read requesters.
- Typical pairing: requester 0 is the SiTCP 8-to-32 read adapter; requester 1 is a local status poller.
- Round-robin arbitration with exactly one outstanding transaction.
- Responses are buffered and returned to the granted requester only.

---
 rtl/axi_rd_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/axi_lite_rd_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg
// Shared definitions for the two-requester AXI4-Lite read arbiter:
//   - state_t      : arbiter FSM encoding (IDLE, ADDR, DATA, RESP)
//   - RESP_OKAY    : AXI OKAY response code
//   - RESP_SLVERR  : AXI SLVERR response code, returned on a watchdog abort
//   - TIMEOUT_DATA : read data returned upstream on a watchdog abort
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way combinational round-robin select.
// Ports:
//   req[1:0] in  : request lines, bit i for requester i
//   last     in  : index of the previously granted requester
//   sel      out : index of the chosen requester (valid when any=1)
//   any      out : at least one request is pending
// On a tie the requester that was not granted last time wins.
module rr_arb2
  import axi_rd_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  // select logic: a lone requester wins outright, a tie alternates
  always_comb begin
    any = |req;
    sel = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last;
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter
// Shares one downstream AXI4-Lite read master between two upstream read
// requesters with round-robin arbitration and one outstanding transaction.
// The response is captured into a shared rdata/rresp register and returned
// only to the requester that owns the transaction.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   s0_axi_* / s1_axi_*  : upstream AXI4-Lite read slaves (AR and R channels)
//   m_axi_*              : downstream AXI4-Lite read master (AR and R channels)
//   grant                : index of the current or last granted requester
//   busy                 : high whenever the FSM is not idle
//
// Optional build macro AXI_RD_ARB_TIMEOUT_EN adds a watchdog: if a
// transaction spends TIMEOUT_CYC cycles in ADDR+DATA it is abandoned and
// SLVERR with data TIMEOUT_DATA is returned. Without the macro the block
// waits indefinitely for the downstream slave.
module axi_lite_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic [2:0]        s0_axi_arprot,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [DATA_W-1:0] s0_axi_rdata,
  output logic [1:0]        s0_axi_rresp,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,

  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic [2:0]        s1_axi_arprot,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [DATA_W-1:0] s1_axi_rdata,
  output logic [1:0]        s1_axi_rresp,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,

  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,

  output logic              grant,
  output logic              busy
);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                s0_arready_q, s0_arready_d;
  logic                s1_arready_q, s1_arready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                s0_rvalid_q, s0_rvalid_d;
  logic                s1_rvalid_q, s1_rvalid_d;
  logic                busy_q, busy_d;

  logic                arb_sel;
  logic                arb_any;
  logic                sel_rready;
  logic                timeout_hit;

  rr_arb2 u_rr_arb2 (
    .req  ({s1_axi_arvalid, s0_axi_arvalid}),
    .last (grant_q),
    .sel  (arb_sel),
    .any  (arb_any)
  );

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        unused_ok;

  // The counter reads TIMEOUT_CYC-1 on the edge that completes the
  // TIMEOUT_CYC-th cycle since ADDR was entered.
  assign timeout_hit = (tmo_cnt_q == TMO_LAST);
  assign unused_ok   = ^{s0_axi_arprot, s1_axi_arprot};

  // watchdog next value: zero while idle so it starts at 0 on ADDR entry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      ST_IDLE:          tmo_cnt_d = 16'd0;
      ST_ADDR, ST_DATA: tmo_cnt_d = tmo_cnt_q + 16'd1;
      default:          tmo_cnt_d = tmo_cnt_q;
    endcase
  end

  // watchdog counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_ok;

  assign timeout_hit = 1'b0;
  assign unused_ok   = ^{s0_axi_arprot, s1_axi_arprot, 32'(TIMEOUT_CYC)};
`endif

  // FSM next-state and registered-output next values
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    s0_arready_d = 1'b0;
    s1_arready_d = 1'b0;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    s0_rvalid_d  = s0_rvalid_q;
    s1_rvalid_d  = s1_rvalid_q;
    sel_rready   = grant_q ? s1_axi_rready : s0_axi_rready;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d   = arb_sel;
          araddr_d  = arb_sel ? s1_axi_araddr : s0_axi_araddr;
          arvalid_d = 1'b1;
          if (arb_sel) begin
            s1_arready_d = 1'b1;
          end else begin
            s0_arready_d = 1'b1;
          end
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (timeout_hit) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          rdata_d   = DATA_W'(TIMEOUT_DATA);
          rresp_d   = RESP_SLVERR;
          if (grant_q) begin
            s1_rvalid_d = 1'b1;
          end else begin
            s0_rvalid_d = 1'b1;
          end
          state_d = ST_RESP;
        end else if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end

      ST_DATA: begin
        if (timeout_hit) begin
          rready_d = 1'b0;
          rdata_d  = DATA_W'(TIMEOUT_DATA);
          rresp_d  = RESP_SLVERR;
          if (grant_q) begin
            s1_rvalid_d = 1'b1;
          end else begin
            s0_rvalid_d = 1'b1;
          end
          state_d = ST_RESP;
        end else if (m_axi_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = m_axi_rdata;
          rresp_d  = m_axi_rresp;
          if (grant_q) begin
            s1_rvalid_d = 1'b1;
          end else begin
            s0_rvalid_d = 1'b1;
          end
          state_d = ST_RESP;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_RESP: begin
        if (sel_rready) begin
          s0_rvalid_d = 1'b0;
          s1_rvalid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // state and output registers; reset leaves grant=1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b1;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      s0_arready_q <= 1'b0;
      s1_arready_q <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      s0_rvalid_q  <= 1'b0;
      s1_rvalid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      s0_arready_q <= s0_arready_d;
      s1_arready_q <= s1_arready_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      s0_rvalid_q  <= s0_rvalid_d;
      s1_rvalid_q  <= s1_rvalid_d;
      busy_q       <= busy_d;
    end
  end

  // The response register is shared; only rvalid tells a requester it is theirs.
  assign s0_axi_arready = s0_arready_q;
  assign s1_axi_arready = s1_arready_q;
  assign s0_axi_rdata   = rdata_q;
  assign s1_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign s1_axi_rresp   = rresp_q;
  assign s0_axi_rvalid  = s0_rvalid_q;
  assign s1_axi_rvalid  = s1_rvalid_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;
  assign grant          = grant_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb_axi_lite_rd_arbiter
// Directed bench for axi_lite_rd_arbiter with a small downstream slave model
// (configurable arready/rvalid wait states). Watchdog scenario is compiled
// only when AXI_RD_ARB_TIMEOUT_EN is defined (TIMEOUT_CYC=16 here).
module tb_axi_lite_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] s0_axi_araddr, s1_axi_araddr;
  logic [2:0]  s0_axi_arprot, s1_axi_arprot;
  logic        s0_axi_arvalid, s1_axi_arvalid;
  logic        s0_axi_arready, s1_axi_arready;
  logic [31:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp;
  logic        s0_axi_rvalid, s1_axi_rvalid;
  logic        s0_axi_rready, s1_axi_rready;

  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        grant;
  logic        busy;

  // free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  axi_lite_rd_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0_axi_araddr  (s0_axi_araddr),
    .s0_axi_arprot  (s0_axi_arprot),
    .s0_axi_arvalid (s0_axi_arvalid),
    .s0_axi_arready (s0_axi_arready),
    .s0_axi_rdata   (s0_axi_rdata),
    .s0_axi_rresp   (s0_axi_rresp),
    .s0_axi_rvalid  (s0_axi_rvalid),
    .s0_axi_rready  (s0_axi_rready),
    .s1_axi_araddr  (s1_axi_araddr),
    .s1_axi_arprot  (s1_axi_arprot),
    .s1_axi_arvalid (s1_axi_arvalid),
    .s1_axi_arready (s1_axi_arready),
    .s1_axi_rdata   (s1_axi_rdata),
    .s1_axi_rresp   (s1_axi_rresp),
    .s1_axi_rvalid  (s1_axi_rvalid),
    .s1_axi_rready  (s1_axi_rready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arprot   (m_axi_arprot),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .grant          (grant),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave data: 0x10 gives a fixed pattern, otherwise {~addr[15:0], addr[15:0]}.
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    logic [31:0] d;
    if (a == 32'h0000_0010) d = 32'h1234_5678;
    else                    d = {~a[15:0], a[15:0]};
    return d;
  endfunction

  int   ar_wait = 0;
  int   r_wait  = 0;
  bit   r_never = 1'b0;
  int   ar_cnt  = 0;
  int   r_cnt   = 0;
  logic r_pend  = 1'b0;

  // downstream slave model: registered arready after ar_wait idle cycles,
  // rvalid r_wait cycles after the address handshake
  always @(posedge clk) begin
    if (!rst_n) begin
      m_axi_arready <= 1'b0;
      m_axi_rvalid  <= 1'b0;
      m_axi_rdata   <= 32'd0;
      m_axi_rresp   <= 2'b00;
      ar_cnt        <= 0;
      r_cnt         <= 0;
      r_pend        <= 1'b0;
    end else begin
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_arready <= 1'b0;
        ar_cnt        <= 0;
        m_axi_rdata   <= slv_data(m_axi_araddr);
        m_axi_rresp   <= 2'b00;
        if (r_never)          r_pend <= 1'b0;
        else if (r_wait == 0) m_axi_rvalid <= 1'b1;
        else begin
          r_pend <= 1'b1;
          r_cnt  <= 1;
        end
      end else if (m_axi_arvalid) begin
        if (ar_cnt >= ar_wait) m_axi_arready <= 1'b1;
        else                   ar_cnt <= ar_cnt + 1;
      end
      if (r_pend) begin
        if (r_cnt >= r_wait) begin
          m_axi_rvalid <= 1'b1;
          r_pend       <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  function automatic logic arr(input int i);
    return (i == 1) ? s1_axi_arready : s0_axi_arready;
  endfunction

  function automatic logic rv(input int i);
    return (i == 1) ? s1_axi_rvalid : s0_axi_rvalid;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [31:0] a);
    if (i == 1) begin
      s1_axi_arvalid = v;
      s1_axi_araddr  = a;
    end else begin
      s0_axi_arvalid = v;
      s0_axi_araddr  = a;
    end
  endtask

  task automatic wait_ar(input int i, input string tag);
    int k = 0;
    while (arr(i) !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check({tag, "_arready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rv(input int i, input string tag);
    int k = 0;
    while (rv(i) !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
  endtask

  // hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int          arv_cyc, addr_bad, busy_low, rv_cyc, data_bad, ar_cyc, s1_ar_bad;
  int          g, k;
  logic [31:0] a0, a1, exp_d;

  // directed stimulus and checks
  initial begin
    rst_n = 1'b0;
    s0_axi_araddr = 32'd0; s0_axi_arprot = 3'b101; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b1;
    s1_axi_araddr = 32'd0; s1_axi_arprot = 3'b011; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", busy, 32'd0);
    check("rst_grant", grant, 32'd1);
    check("rst_m_arvalid", m_axi_arvalid, 32'd0);
    check("rst_m_rready", m_axi_rready, 32'd0);
    check("rst_m_araddr", m_axi_araddr, 32'd0);
    check("rst_s0_arready", s0_axi_arready, 32'd0);
    check("rst_s0_rvalid", s0_axi_rvalid, 32'd0);
    check("rst_s1_rvalid", s1_axi_rvalid, 32'd0);
    check("rst_rdata", s0_axi_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single s0 read with a zero-wait slave
    set_req(0, 1'b1, 32'h0000_0010);
    @(negedge clk);
    check("t1_arready_after_1", s0_axi_arready, 32'd1);
    check("t1_s1_arready", s1_axi_arready, 32'd0);
    check("t1_m_araddr", m_axi_araddr, 32'h0000_0010);
    check("t1_arprot", m_axi_arprot, 32'd0);
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_0010);
    check("t1_arready_pulse", s0_axi_arready, 32'd0);
    @(negedge clk);
    check("t1_rvalid_not_at_3", s0_axi_rvalid, 32'd0);
    @(negedge clk);
    check("t1_rvalid_at_4", s0_axi_rvalid, 32'd1);
    check("t1_rdata", s0_axi_rdata, 32'h1234_5678);
    check("t1_rresp", s0_axi_rresp, 32'd0);
    check("t1_s1_rvalid", s1_axi_rvalid, 32'd0);
    @(negedge clk);
    check("t1_rvalid_drop", s0_axi_rvalid, 32'd0);
    check("t1_busy_drop", busy, 32'd0);

    // slave with 5 arready wait cycles and 7 rvalid wait cycles
    ar_wait = 5; r_wait = 7;
    set_req(0, 1'b1, 32'h0000_0200);
    @(negedge clk);
    arv_cyc = 0; addr_bad = 0; busy_low = 0; rv_cyc = 0; data_bad = 0; ar_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) set_req(0, 1'b0, 32'h0000_0200);
      if (s0_axi_arready === 1'b1) ar_cyc++;
      if (m_axi_arvalid === 1'b1) begin
        arv_cyc++;
        if (m_axi_araddr !== 32'h0000_0200) addr_bad++;
      end
      if (s0_axi_rvalid === 1'b1) begin
        rv_cyc++;
        if (s0_axi_rdata !== 32'hFDFF_0200) data_bad++;
      end else if (rv_cyc == 0 && busy !== 1'b1) begin
        busy_low++;
      end
      @(negedge clk);
    end
    check("t3_arvalid_cycles", arv_cyc, 32'd7);
    check("t3_araddr_unstable", addr_bad, 32'd0);
    check("t3_arready_cycles", ar_cyc, 32'd1);
    check("t3_rvalid_once", rv_cyc, 32'd1);
    check("t3_rdata_bad", data_bad, 32'd0);
    check("t3_busy_low", busy_low, 32'd0);
    check("t3_busy_end", busy, 32'd0);
    ar_wait = 0; r_wait = 0;

    // s0 holds rready low in RESP while s1 requests
    s0_axi_rready = 1'b0;
    set_req(0, 1'b1, 32'h0000_0300);
    @(negedge clk);
    wait_ar(0, "t4");
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_0300);
    wait_rv(0, "t4");
    set_req(1, 1'b1, 32'h0000_0340);
    data_bad = 0; s1_ar_bad = 0; rv_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s0_axi_rvalid === 1'b1) rv_cyc++;
      if (s0_axi_rdata !== 32'hFCFF_0300) data_bad++;
      if (s1_axi_arready !== 1'b0) s1_ar_bad++;
    end
    check("t4_rvalid_held", rv_cyc, 32'd10);
    check("t4_rdata_held", data_bad, 32'd0);
    check("t4_s1_not_accepted", s1_ar_bad, 32'd0);
    s0_axi_rready = 1'b1;
    @(negedge clk);
    check("t4_rvalid_exit", s0_axi_rvalid, 32'd0);
    check("t4_s1_arready_idle", s1_axi_arready, 32'd0);
    @(negedge clk);
    check("t4_s1_arready", s1_axi_arready, 32'd1);
    check("t4_grant", grant, 32'd1);
    @(negedge clk);
    set_req(1, 1'b0, 32'h0000_0340);
    wait_rv(1, "t4s1");
    check("t4_s1_rdata", s1_axi_rdata, 32'hFCBF_0340);
    check("t4_s0_rvalid", s0_axi_rvalid, 32'd0);
    @(negedge clk);

    // reset asserted while in DATA
    r_wait = 7;
    set_req(0, 1'b1, 32'h0000_0400);
    @(negedge clk);
    wait_ar(0, "t5");
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_0400);
    @(negedge clk);
    check("t5_in_data", m_axi_rready, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 32'd0);
    check("t5_grant", grant, 32'd1);
    check("t5_m_rready", m_axi_rready, 32'd0);
    check("t5_m_arvalid", m_axi_arvalid, 32'd0);
    check("t5_m_araddr", m_axi_araddr, 32'd0);
    check("t5_rdata", s0_axi_rdata, 32'd0);
    check("t5_s0_rvalid", s0_axi_rvalid, 32'd0);
    rst_n = 1'b1; r_wait = 0;
    set_req(1, 1'b1, 32'h0000_0500);
    @(negedge clk);
    wait_ar(1, "t5s1");
    check("t5_s1_grant", grant, 32'd1);
    @(negedge clk);
    set_req(1, 1'b0, 32'h0000_0500);
    wait_rv(1, "t5s1");
    check("t5_s1_rdata", s1_axi_rdata, 32'hFAFF_0500);
    check("t5_s0_rvalid_quiet", s0_axi_rvalid, 32'd0);
    @(negedge clk);

    // both requesters contend four times; last grant was 1 so order is 0,1,0,1
    a0 = 32'h0000_1000; a1 = 32'h0000_2000;
    set_req(0, 1'b1, a0);
    set_req(1, 1'b1, a1);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      k = 0;
      while (s0_axi_arready !== 1'b1 && s1_axi_arready !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) check("rr_arready_timeout", 32'd0, 32'd1);
      g = (s1_axi_arready === 1'b1) ? 1 : 0;
      check("rr_sel", g, r % 2);
      check("rr_grant", grant, r % 2);
      exp_d = slv_data((g == 1) ? a1 : a0);
      @(negedge clk);
      set_req(g, 1'b0, (g == 1) ? a1 : a0);
      wait_rv(g, "rr");
      check("rr_rdata", (g == 1) ? s1_axi_rdata : s0_axi_rdata, exp_d);
      check("rr_other_rvalid", (g == 1) ? s0_axi_rvalid : s1_axi_rvalid, 32'd0);
      @(negedge clk);
      if (g == 1) a1 = a1 + 32'd4;
      else        a0 = a0 + 32'd4;
      if (r < 3) begin
        set_req(g, 1'b1, (g == 1) ? a1 : a0);
      end else begin
        set_req(0, 1'b0, a0);
        set_req(1, 1'b0, a1);
      end
    end
    @(negedge clk);
    check("rr_busy_end", busy, 32'd0);

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // slave never answers; watchdog aborts 16 cycles after ADDR entry
    r_never = 1'b1;
    set_req(0, 1'b1, 32'h0000_0600);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 2) set_req(0, 1'b0, 32'h0000_0600);
      if (c == 16) check("tmo_rvalid_early", s0_axi_rvalid, 32'd0);
      if (c == 17) begin
        check("tmo_rvalid", s0_axi_rvalid, 32'd1);
        check("tmo_rresp", s0_axi_rresp, 32'd2);
        check("tmo_rdata", s0_axi_rdata, 32'hDEAD_BEEF);
        check("tmo_m_rready", m_axi_rready, 32'd0);
      end
      if (c == 18) check("tmo_busy_fall", busy, 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
